// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Provides the arbiter state encoding, the requester/owner encoding,
// the default memory read latency and the latency counter width.
package dmem_arb_pkg;
   typedef enum logic {IDLE, RD_WAIT} state_e;
   typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} owner_e;
   localparam int MEM_LAT_DEF = 1;
   localparam int LAT_W       = 3;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: combinational two-requester round-robin picker.
// Ports: en_i allows a grant this cycle; req_i[0]/req_i[1] are the requests
// of requester 0/1; last_i is the index that won most recently.
// gnt_o is one-hot (or zero); win_o is the winning index (meaningless
// when gnt_o is zero).
module dmem_rr_pick (
   input  logic       en_i,
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o,
   output logic       win_o
);
   // with both requesting, the one that did not win last time goes first
   assign win_o = req_i == 2'b11 ? ~last_i : req_i[1];
   assign gnt_o = en_i && req_i != 2'b00 ? (win_o ? 2'b10 : 2'b01) : 2'b00;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between CPU and debug ports.
// Ports: clk_i, reset_i (async, active-high);
// cpu_*/dbg_* : req/we/addr/wdata in, one-cycle gnt out, rvalid/rdata response out;
// mem_*       : en/we/addr/wdata to memory, rdata back MEM_LAT cycles after a read;
// cpu_wait_cnt_o : saturating count of cycles the CPU requested without a grant.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = MEM_LAT_DEF,
   parameter int CNT_W   = 16
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [31:0]       cpu_wdata_i,
   output logic              cpu_gnt_o,
   output logic              cpu_rvalid_o,
   output logic [31:0]       cpu_rdata_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [31:0]       dbg_wdata_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic [31:0]       dbg_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i,
   output logic [CNT_W-1:0]  cpu_wait_cnt_o
);
   state_e           state_q, state_d;
   owner_e           owner_q, owner_d, last_q, last_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             resp, pick_en, win, rd_gnt;
   logic [1:0]       gnt;

   // response cycle: read data is on mem_rdata_i and the port is free again
   assign resp    = state_q == RD_WAIT && lat_q == LAT_W'(MEM_LAT);
   assign pick_en = ~reset_i && (state_q == IDLE || resp);

   dmem_rr_pick u_pick (
      .en_i  (pick_en),
      .req_i ({dbg_req_i, cpu_req_i}),
      .last_i(last_q),
      .gnt_o (gnt),
      .win_o (win)
   );

   assign cpu_gnt_o      = gnt[0];
   assign dbg_gnt_o      = gnt[1];
   assign mem_en_o       = |gnt;
   assign mem_we_o       = mem_en_o && (win ? dbg_we_i : cpu_we_i);
   assign mem_addr_o     = win ? dbg_addr_i : cpu_addr_i;
   assign mem_wdata_o    = win ? dbg_wdata_i : cpu_wdata_i;
   assign rd_gnt         = mem_en_o && !mem_we_o;
   assign cpu_rvalid_o   = resp && owner_q == OWN_CPU;
   assign dbg_rvalid_o   = resp && owner_q == OWN_DBG;
   assign cpu_rdata_o    = cpu_rvalid_o ? mem_rdata_i : '0;
   assign dbg_rdata_o    = dbg_rvalid_o ? mem_rdata_i : '0;
   assign cpu_wait_cnt_o = cnt_q;

   always_comb begin
      last_d  = mem_en_o ? owner_e'(win) : last_q;
      owner_d = rd_gnt ? owner_e'(win) : owner_q;
      state_d = rd_gnt || (state_q == RD_WAIT && !resp) ? RD_WAIT : IDLE;
      lat_d   = rd_gnt ? LAT_W'(1) : state_d == RD_WAIT ? lat_q + LAT_W'(1) : '0;
      cnt_d   = cpu_req_i && !cpu_gnt_o && cnt_q != '1 ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         owner_q <= OWN_CPU;
         last_q  <= OWN_DBG;
         lat_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         lat_q   <= lat_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: three arbiters (MEM_LAT 1,2,3; CNT_W 4) on shared stimulus,
// checked every cycle against a timestamp-based model plus directed literals.
module tb_dmem_arbiter;
   logic        clk = 0, reset;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [7:0]  cpu_addr, dbg_addr;
   logic [31:0] cpu_wdata, dbg_wdata;
   logic        cpu_gnt [3], cpu_rvalid [3], dbg_gnt [3], dbg_rvalid [3];
   logic        mem_en [3], mem_we [3];
   logic [31:0] cpu_rdata [3], dbg_rdata [3], mem_wdata [3], mem_rdata [3];
   logic [7:0]  mem_addr [3];
   logic [3:0]  cpu_wait_cnt [3];
   logic        s_en [3], s_we [3];
   logic [7:0]  s_addr [3];
   logic [31:0] s_wd [3];
   logic [31:0] mem [3][64];
   logic [31:0] pipe [3][4];
   logic        out_m [3], own_m [3], last_m [3];
   int          due_m [3], cnt_m [3];
   logic [31:0] dat_m [3];
   int          cyc = 0, n_chk = 0, n_fail = 0;

   typedef struct packed {
      logic cg, dg, en, we, cv, dv;
      logic [7:0] addr;
      logic [31:0] wd, rd;
   } exp_t;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_arbiter #(.ADDR_W(8), .MEM_LAT(g + 1), .CNT_W(4)) u_dut (
         .clk_i(clk), .reset_i(reset),
         .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
         .cpu_gnt_o(cpu_gnt[g]), .cpu_rvalid_o(cpu_rvalid[g]), .cpu_rdata_o(cpu_rdata[g]),
         .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
         .dbg_gnt_o(dbg_gnt[g]), .dbg_rvalid_o(dbg_rvalid[g]), .dbg_rdata_o(dbg_rdata[g]),
         .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
         .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(mem_rdata[g]),
         .cpu_wait_cnt_o(cpu_wait_cnt[g])
      );
      assign mem_rdata[g] = pipe[g][g];
   end

   task automatic chk(input string n, input int k, input logic [31:0] a, input logic [31:0] x);
      n_chk++;
      if (a !== x) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %0h expected %0h (t=%0t)", n, k, a, x, $time);
      end
   endtask

   // expected outputs of arbiter k in the current cycle
   function automatic exp_t predict(int k);
      exp_t e;
      logic resp, win;
      e = '0;
      if (reset) return e;
      resp = out_m[k] && cyc == due_m[k];
      if ((!out_m[k] || resp) && (cpu_req || dbg_req)) begin
         win    = cpu_req && dbg_req ? !last_m[k] : dbg_req;
         e.cg   = !win;
         e.dg   = win;
         e.en   = 1;
         e.we   = win ? dbg_we : cpu_we;
         e.addr = win ? dbg_addr : cpu_addr;
         e.wd   = win ? dbg_wdata : cpu_wdata;
      end
      if (resp) begin
         e.cv = !own_m[k];
         e.dv = own_m[k];
         e.rd = dat_m[k];
      end
      return e;
   endfunction

   initial begin
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 64; i++) mem[k][i] = i * 20;
         for (int j = 0; j < 4; j++) pipe[k][j] = 0;
         out_m[k] = 0; own_m[k] = 0; last_m[k] = 1; due_m[k] = 0; cnt_m[k] = 0; dat_m[k] = 0;
      end
   end

   // memory environment: writes land at the grant edge, reads return MEM_LAT cycles later
   always @(posedge clk)
      for (int k = 0; k < 3; k++) begin
         if (s_en[k] && s_we[k]) mem[k][s_addr[k][7:2]] <= s_wd[k];
         pipe[k][0] <= s_en[k] && !s_we[k] ? mem[k][s_addr[k][7:2]] : 32'hdead_beef;
         for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
      end

   // model state update
   always @(posedge clk) begin
      exp_t u;
      for (int k = 0; k < 3; k++) begin
         u = predict(k);
         if (reset) begin
            out_m[k] = 0; last_m[k] = 1; cnt_m[k] = 0;
         end else begin
            if (u.en) last_m[k] = u.dg;
            if (u.en && !u.we) begin
               out_m[k] = 1; own_m[k] = u.dg; due_m[k] = cyc + k + 1;
               dat_m[k] = mem[k][u.addr[7:2]];
            end else if (out_m[k] && cyc == due_m[k]) out_m[k] = 0;
            if (cpu_req && !u.cg && cnt_m[k] < 15) cnt_m[k]++;
         end
      end
      cyc++;
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         s_en[k] = mem_en[k]; s_we[k] = mem_we[k]; s_addr[k] = mem_addr[k]; s_wd[k] = mem_wdata[k];
         e = predict(k);
         chk("m_cpu_gnt", k, cpu_gnt[k], e.cg);
         chk("m_dbg_gnt", k, dbg_gnt[k], e.dg);
         chk("m_mem_en", k, mem_en[k], e.en);
         chk("m_mem_we", k, mem_we[k], e.en && e.we);
         chk("m_cpu_rvalid", k, cpu_rvalid[k], e.cv);
         chk("m_dbg_rvalid", k, dbg_rvalid[k], e.dv);
         chk("m_cpu_rdata", k, cpu_rdata[k], e.cv ? e.rd : 0);
         chk("m_dbg_rdata", k, dbg_rdata[k], e.dv ? e.rd : 0);
         chk("m_wait_cnt", k, cpu_wait_cnt[k], reset ? 0 : cnt_m[k]);
         if (e.en) begin
            chk("m_mem_addr", k, mem_addr[k], e.addr);
            chk("m_mem_wdata", k, mem_wdata[k], e.wd);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(int n);
      cpu_req = 0;
      dbg_req = 0;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1;
      cpu_req = 0;
      dbg_req = 0;
      tick();
      tick();
      reset = 0;
   endtask

   initial begin
      reset = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
      tick(); #3;
      chk("rst_gnt", 0, cpu_gnt[0], 0);
      chk("rst_en", 0, mem_en[0], 0);
      chk("rst_cnt", 0, cpu_wait_cnt[0], 0);
      // 1: single CPU read, latency 1
      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h04; #3;
      chk("t1_gnt", 0, cpu_gnt[0], 1);
      chk("t1_en", 0, mem_en[0], 1);
      chk("t1_addr", 0, mem_addr[0], 8'h04);
      tick(); cpu_req = 0; #3;
      chk("t1_rvalid", 0, cpu_rvalid[0], 1);
      chk("t1_rdata", 0, cpu_rdata[0], 20);
      chk("t1_dbg_rvalid", 0, dbg_rvalid[0], 0);
      idle(4);
      // 2: simultaneous reads, CPU first after reset
      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
      dbg_req = 1; dbg_we = 0; dbg_addr = 8'h14; #3;
      chk("t2_cpu_gnt", 0, cpu_gnt[0], 1);
      chk("t2_dbg_gnt0", 0, dbg_gnt[0], 0);
      tick(); cpu_req = 0; #3;
      chk("t2_cpu_rvalid", 0, cpu_rvalid[0], 1);
      chk("t2_cpu_rdata", 0, cpu_rdata[0], 80);
      chk("t2_dbg_gnt1", 0, dbg_gnt[0], 1);
      chk("t2_addr", 0, mem_addr[0], 8'h14);
      tick(); dbg_req = 0; #3;
      chk("t2_dbg_rvalid", 0, dbg_rvalid[0], 1);
      chk("t2_dbg_rdata", 0, dbg_rdata[0], 100);
      chk("t2_cnt", 0, cpu_wait_cnt[0], 0);
      idle(4);
      // 3: competing writes alternate, then read one back
      do_reset();
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h08; cpu_wdata = 30;
      dbg_req = 1; dbg_we = 1; dbg_addr = 8'h0c; dbg_wdata = 40;
      for (int i = 0; i < 4; i++) begin
         #3;
         chk("t3_cpu_gnt", 0, cpu_gnt[0], i % 2 == 0);
         chk("t3_dbg_gnt", 0, dbg_gnt[0], i % 2 == 1);
         chk("t3_we", 0, mem_we[0], 1);
         chk("t3_addr", 0, mem_addr[0], i % 2 == 0 ? 8'h08 : 8'h0c);
         chk("t3_wdata", 0, mem_wdata[0], i % 2 == 0 ? 30 : 40);
         tick();
      end
      cpu_we = 0; cpu_addr = 8'h0c; dbg_req = 0; #3;
      chk("t3_rd_gnt", 0, cpu_gnt[0], 1);
      tick(); cpu_req = 0; #3;
      chk("t3_rd_rvalid", 0, cpu_rvalid[0], 1);
      chk("t3_rd_data", 0, cpu_rdata[0], 40);
      idle(4);
      // 4: latency 3, CPU write waits behind debug read
      do_reset();
      dbg_req = 1; dbg_we = 0; dbg_addr = 8'h18; #3;
      chk("t4_dbg_gnt", 2, dbg_gnt[2], 1);
      tick(); dbg_req = 0; cpu_req = 1; cpu_we = 1; cpu_addr = 8'h20; cpu_wdata = 55; #3;
      chk("t4_hold1", 2, cpu_gnt[2], 0);
      tick(); #3;
      chk("t4_hold2", 2, cpu_gnt[2], 0);
      tick(); #3;
      chk("t4_cpu_gnt", 2, cpu_gnt[2], 1);
      chk("t4_dbg_rvalid", 2, dbg_rvalid[2], 1);
      chk("t4_dbg_rdata", 2, dbg_rdata[2], 120);
      chk("t4_cnt", 2, cpu_wait_cnt[2], 2);
      tick(); cpu_req = 0; #3;
      chk("t4_cnt_after", 2, cpu_wait_cnt[2], 2);
      idle(4);
      // 5: latency 2, reset kills an outstanding read
      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h04; #3;
      chk("t5_cpu_gnt", 1, cpu_gnt[1], 1);
      tick(); cpu_req = 0; reset = 1; #3;
      chk("t5_rv_rst", 1, cpu_rvalid[1], 0);
      tick(); reset = 0; dbg_req = 1; dbg_we = 0; dbg_addr = 8'h24; #3;
      chk("t5_rv_late", 1, cpu_rvalid[1], 0);
      chk("t5_dbg_gnt", 1, dbg_gnt[1], 1);
      tick(); dbg_req = 0; #3;
      chk("t5_rv_none", 1, cpu_rvalid[1], 0);
      tick(); #3;
      chk("t5_dbg_rvalid", 1, dbg_rvalid[1], 1);
      chk("t5_dbg_rdata", 1, dbg_rdata[1], 180);
      idle(4);
      // 6: sustained contention saturates the 4-bit wait counter
      do_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h04;
      dbg_req = 1; dbg_we = 0; dbg_addr = 8'h08;
      repeat (60) tick();
      #3;
      for (int k = 0; k < 3; k++) chk("t6_sat", k, cpu_wait_cnt[k], 15);
      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
